riscv_ex_muldiv: RTL and testbench
==================================

Name: riscv_ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes that register's forwarded operands, funct3 and rd address whenever the decoded instruction is an M-extension op. It computes the result over a fixed number of cycles, stalling the front of the pipeline until done. It presents a registered result, for one cycle, to the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; only 32 is supported. Counter width is clog2(XLEN).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  ID/EX holds a valid M-op (opcode 0110011, funct7 0000001), not flushed
flush  in  1  abort the in-flight op (branch/jump redirect)
funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  in  XLEN  forwarded operand A
rs2_val  in  XLEN  forwarded operand B
rd_in  in  5  destination register
stall  out  1  combinational; holds PC, IF/ID and ID/EX
busy  out  1  registered; state != IDLE
result  out  XLEN  registered result
result_valid  out  1  registered; one-cycle pulse
rd_out  out  5  registered rd of the completed op

Behaviour:
- States: IDLE, CALC, DONE.
- Reset values (rst at a clk edge):
  - state=IDLE, count=0, result=0, result_valid=0, rd_out=0, busy=0.
  - Internal accumulators are cleared.
  - stall=0 while rst is high.
  - rst mid-operation drops the op silently.
- stall = (state==IDLE && start && !flush) || state==CALC. It is low in DONE, so ID/EX advances in that cycle.
- IDLE, start=1, flush=0:
  - Latch funct3, rd_in and operand magnitudes: take |x| for signed operands per op; MULHU/DIVU/REMU and the unsigned operand of MULHSU are taken as-is.
  - Record the result sign. Clear the accumulator and set count=0.
  - Next state is CALC, or DONE for the special cases below.
- Special cases go IDLE->DONE with no iteration (result in DONE, one cycle after start):
  - DIV/DIVU by 0: quotient 0xFFFFFFFF.
  - REM/REMU by 0: rs1_val.
  - DIV 0x80000000 / 0xFFFFFFFF: 0x80000000.
  - REM of the same operands: 0.
- CALC: one iteration per cycle, 32 iterations (count 0..31); DONE after count==31.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle, 32-bit remainder plus 1 guard bit.
- Entering DONE:
  - Apply sign fix (two's-complement negate of the 64-bit product, quotient or remainder).
  - Register the result; result_valid=1 for exactly one cycle; next state IDLE.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - Remainder sign follows the dividend; quotient is negative iff the operand signs differ (signed ops only).
- Latency from the start cycle: 33 cycles to result_valid for normal ops, 1 cycle for special cases.
- start is ignored in CALC and DONE. In DONE, the same instruction is still in ID/EX and must not restart.
- flush in any state: next state IDLE; no result_valid is produced; stall=0 in the flush cycle. flush wins over start.
- rd_in=0 is still computed; writeback suppresses the write.
- result and rd_out hold their values when result_valid=0.

Decomposition:
- Package riscv_muldiv_pkg:
  - funct3 op constants (MUL..REMU).
  - State enum (IDLE/CALC/DONE).
  - XLEN default and the special-case constants 0xFFFFFFFF / 0x80000000.
- No sub-module needed; the shift-add and restoring datapaths share the accumulator and count in one block.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> stall high cycles 0-32; result_valid at cycle 33, result=0xFFFFFFEB, rd_out=rd_in.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); each at cycle 33.
- DIVU 123/0 -> 0xFFFFFFFF at cycle 1 with stall high only in cycle 0; REM 123/0 -> 123; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU 100/7, flush at cycle 10 -> stall low that cycle, busy low from cycle 11, no result_valid; a new MUL 3*4 started at cycle 12 -> result 12 at cycle 45.
- start held high through DONE and the following cycle -> exactly one result_valid; rst at cycle 5 mid-op -> all outputs zero next cycle, no result_valid.

Source files
------------

// File: rtl/riscv_ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage RV32M multiply/divide unit.
package riscv_muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // funct3 encodings of the M-extension R-type ops
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Architected results for divide-by-zero and signed overflow
  localparam logic [XLEN_DEF-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEF-1:0] SIGN_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/riscv_ex_muldiv_if.sv
// ID/EX -> muldiv -> EX/MEM signal bundle; master is the pipeline, slave the unit.
interface riscv_ex_muldiv_if
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_in,
    input  stall, busy, result, result_valid, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_in,
    output stall, busy, result, result_valid, rd_out
  );
endinterface

// File: rtl/riscv_ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide share one 64-bit accumulator, one bit per cycle over 32 cycles.
module riscv_ex_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input logic              clk,
  input logic              rst,
  riscv_ex_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd;      // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc;       // {hi, lo}: product/multiplier or remainder/quotient
  logic [XLEN-1:0]   result_q;
  logic              result_valid_q;
  logic              busy_q;
  logic [4:0]        rd_out_q;

  // operand decode for a new op
  logic            is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;

  // one iteration step and final sign fix
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  assign bus.stall        = !rst && !bus.flush &&
                            ((state == IDLE && bus.start) || state == CALC);
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.rd_out       = rd_out_q;

  // Decode signedness, magnitudes, result sign and the no-iteration cases
  always_comb begin
    is_div_in = bus.funct3[2];
    a_signed  = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                (bus.funct3 == F3_MULHSU) || (bus.funct3 == F3_DIV) ||
                (bus.funct3 == F3_REM);
    b_signed  = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    a_neg     = a_signed && bus.rs1_val[XLEN-1];
    b_neg     = b_signed && bus.rs2_val[XLEN-1];
    a_mag     = a_neg ? (-bus.rs1_val) : bus.rs1_val;
    b_mag     = b_neg ? (-bus.rs2_val) : bus.rs2_val;
    unique case (bus.funct3)
      F3_MUL, F3_MULH, F3_DIV: neg_in = a_neg ^ b_neg;
      F3_MULHSU, F3_REM:       neg_in = a_neg;
      default:                 neg_in = 1'b0;
    endcase
    special     = 1'b0;
    special_res = '0;
    if (is_div_in && bus.rs2_val == '0) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.rs1_val : ALL_ONES;
    end else if ((bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
                 bus.rs1_val == SIGN_MIN && bus.rs2_val == '1) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? '0 : SIGN_MIN;
    end
  end

  // One shift-add / restoring-divide step plus the sign-fixed final result
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    acc_next  = op_q[2] ? div_next : mul_next;
    prod_fix  = neg_q ? (-acc_next) : acc_next;
    quo_fix   = neg_q ? (-acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
    rem_fix   = neg_q ? (-acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];
    unique case (op_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // Control FSM with registered outputs; flush and reset abandon the op
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      neg_q          <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      rd_out_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        count  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              op_q   <= bus.funct3;
              rd_q   <= bus.rd_in;
              neg_q  <= neg_in;
              count  <= '0;
              busy_q <= 1'b1;
              if (special) begin
                opnd           <= '0;
                acc            <= '0;
                result_q       <= special_res;
                rd_out_q       <= bus.rd_in;
                result_valid_q <= 1'b1;
                state          <= DONE;
              end else begin
                // mul: multiplier sits in acc low half; div: dividend does
                opnd  <= is_div_in ? b_mag : a_mag;
                acc   <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (count == '1) begin
              result_q       <= final_res;
              rd_out_q       <= rd_q;
              result_valid_q <= 1'b1;
              state          <= DONE;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_muldiv.sv
// Directed-vector bench for riscv_ex_muldiv; inputs change on negedge.
module tb_riscv_ex_muldiv;
  import riscv_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  riscv_ex_muldiv_if #(.XLEN(32)) bus ();

  riscv_ex_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Start an op in the current cycle (cycle 0), then track it to completion
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    int stall_cycles;
    lat = -1;
    stall_cycles = 0;
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (c > 0 && bus.result_valid) begin
        lat = c;
        break;
      end
      if (bus.stall) stall_cycles++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_cycles, exp_lat);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_rd_out"}, {27'b0, bus.rd_out}, {27'b0, rd});
    check({tag, "_stall_done"}, bus.stall, 0);
    @(negedge clk);
    #1;
    check({tag, "_pulse_end"}, bus.result_valid, 0);
    check({tag, "_result_hold"}, bus.result, exp);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.funct3  = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", bus.result, 0);
    check("reset_valid", bus.result_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rd_out", {27'b0, bus.rd_out}, 0);
    bus.start = 1'b1;
    #1;
    check("reset_stall", bus.stall, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    do_op("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    do_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 33);
    do_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 33);
    do_op("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    do_op("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    do_op("divu0",  F3_DIVU,   32'd123,        32'd0,         5'd11, 32'hFFFF_FFFF, 1);
    do_op("rem0",   F3_REM,    32'd123,        32'd0,         5'd12, 32'd123,       1);
    do_op("divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    do_op("removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1);
    do_op("divu",   F3_DIVU,   32'd100,        32'd7,         5'd15, 32'd14,        33);
    do_op("remu",   F3_REMU,   32'd100,        32'd7,         5'd0,  32'd2,         33);

    // flush mid-divide at cycle 10, new multiply at cycle 12
    bus.start   = 1'b1;
    bus.funct3  = F3_DIVU;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    bus.rd_in   = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", bus.stall, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_busy", bus.busy, 0);
    check("flush_no_valid", bus.result_valid, 0);
    @(negedge clk);
    do_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 5'd4, 32'd12, 33);

    // start held through DONE and the following cycle
    nv = 0;
    bus.start   = 1'b1;
    bus.funct3  = F3_MUL;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd6;
    bus.rd_in   = 5'd9;
    for (int c = 0; c < 35; c++) begin
      #1;
      if (bus.result_valid) begin
        nv++;
        check("held_result", bus.result, 32'd30);
      end
      @(negedge clk);
    end
    check("held_one_valid", nv, 1);
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("held_flushed_busy", bus.busy, 0);
    @(negedge clk);

    // flush wins over start in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("flushwin_stall", bus.stall, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flushwin_busy", bus.busy, 0);
    @(negedge clk);

    // reset at cycle 5 of a divide
    bus.start   = 1'b1;
    bus.funct3  = F3_DIV;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd3;
    bus.rd_in   = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_stall", bus.stall, 0);
    @(negedge clk);
    #1;
    check("rst_result", bus.result, 0);
    check("rst_rd_out", {27'b0, bus.rd_out}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.result_valid) nv++;
    end
    check("rst_no_valid", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
